// File: rtl/bus_ctrl_sequencer_pkg.sv
// Shared types and constants for the bus control microsequencer: state encoding,
// opcodes, bus source indices and the decoded control-strobe bundle.
package bus_ctrl_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_END
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_SHR  = 5'd5;
   localparam logic [4:0] OP_SHL  = 5'd6;
   localparam logic [4:0] OP_ROR  = 5'd7;
   localparam logic [4:0] OP_ROL  = 5'd8;
   localparam logic [4:0] OP_AND  = 5'd9;
   localparam logic [4:0] OP_OR   = 5'd10;
   localparam logic [4:0] OP_MUL  = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;
   localparam logic [4:0] OP_MFHI = 5'd24;
   localparam logic [4:0] OP_MFLO = 5'd25;

   // Bus source indices above the register file, shared with the bus encoder/mux
   localparam logic [4:0] SRC_HI     = 5'd16;
   localparam logic [4:0] SRC_LO     = 5'd17;
   localparam logic [4:0] SRC_ZHI    = 5'd18;
   localparam logic [4:0] SRC_ZLO    = 5'd19;
   localparam logic [4:0] SRC_PC     = 5'd20;
   localparam logic [4:0] SRC_MDR    = 5'd21;
   localparam logic [4:0] SRC_INPORT = 5'd22;
   localparam logic [4:0] SRC_C      = 5'd23;

   typedef struct packed {
      logic [31:0] bus_drive;
      logic [15:0] r_in;
      logic        pc_in;
      logic        mar_in;
      logic        mdr_in;
      logic        ir_in;
      logic        y_in;
      logic        z_in;
      logic        hi_in;
      logic        lo_in;
      logic        inc_pc;
      logic        mem_read;
      logic [4:0]  alu_op;
      logic        done;
      logic        illegal;
   } ctrl_t;

   function automatic logic [31:0] src_sel(input logic [4:0] idx);
      return 32'd1 << idx;
   endfunction

   function automatic logic is_alu(input logic [4:0] op);
      return op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                        OP_AND, OP_OR, OP_NEG, OP_NOT};
   endfunction

   function automatic logic is_muldiv(input logic [4:0] op);
      return op inside {OP_MUL, OP_DIV};
   endfunction

endpackage

// File: rtl/bus_ctrl_decode.sv
// Combinational map from sequencer state and IR fields to the control strobes.
// Only one bus source is ever selected; T1 drives Zlow only on its first cycle.
module bus_ctrl_decode
   import bus_ctrl_sequencer_pkg::*;
(
   input  state_t     state,
   input  logic       t1_first,
   input  logic [4:0] opcode,
   input  logic [3:0] ra,
   input  logic [3:0] rb,
   input  logic [3:0] rc,
   output ctrl_t      ctrl
);

   logic [15:0] ra_hot;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_ra_hot
         assign ra_hot[gi] = (ra == 4'(gi));
      end
   endgenerate

   always_comb begin
      ctrl = '0;
      case (state)
         ST_T0: begin
            ctrl.bus_drive = src_sel(SRC_PC);
            ctrl.mar_in    = 1'b1;
            ctrl.inc_pc    = 1'b1;
            ctrl.z_in      = 1'b1;
         end
         ST_T1: begin
            ctrl.mem_read = 1'b1;
            ctrl.mdr_in   = 1'b1;
            // PC must advance exactly once no matter how long memory stalls
            if (t1_first) begin
               ctrl.bus_drive = src_sel(SRC_ZLO);
               ctrl.pc_in     = 1'b1;
            end
         end
         ST_T2: begin
            ctrl.bus_drive = src_sel(SRC_MDR);
            ctrl.ir_in     = 1'b1;
         end
         ST_T3: begin
            if (is_alu(opcode) || is_muldiv(opcode)) begin
               ctrl.bus_drive = src_sel({1'b0, rb});
               ctrl.y_in      = 1'b1;
            end else if (opcode == OP_MFHI) begin
               ctrl.bus_drive = src_sel(SRC_HI);
               ctrl.r_in      = ra_hot;
               ctrl.done      = 1'b1;
            end else if (opcode == OP_MFLO) begin
               ctrl.bus_drive = src_sel(SRC_LO);
               ctrl.r_in      = ra_hot;
               ctrl.done      = 1'b1;
            end else begin
               ctrl.illegal = 1'b1;
            end
         end
         ST_T4: begin
            ctrl.bus_drive = src_sel({1'b0, rc});
            ctrl.alu_op    = opcode;
            ctrl.z_in      = 1'b1;
         end
         ST_T5: begin
            ctrl.bus_drive = src_sel(SRC_ZLO);
            if (is_muldiv(opcode)) begin
               ctrl.lo_in = 1'b1;
            end else begin
               ctrl.r_in = ra_hot;
               ctrl.done = 1'b1;
            end
         end
         ST_T6: begin
            ctrl.bus_drive = src_sel(SRC_ZHI);
            ctrl.hi_in     = 1'b1;
            ctrl.done      = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/bus_ctrl_sequencer.sv
// Single-bus datapath microsequencer: fetch T0-T2, execute T3-T6, END.
// Optional memory-timeout fault enabled by defining BUS_SEQ_MEM_TIMEOUT_EN.
module bus_ctrl_sequencer
   import bus_ctrl_sequencer_pkg::*;
#(
   parameter int          MEM_TIMEOUT = 16,
   parameter logic [31:0] PC_RESET    = 32'h0
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   input  logic        start,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   output logic [31:0] bus_drive,
   output logic [15:0] r_in,
   output logic        pc_in,
   output logic        mar_in,
   output logic        mdr_in,
   output logic        ir_in,
   output logic        y_in,
   output logic        z_in,
   output logic        hi_in,
   output logic        lo_in,
   output logic        inc_pc,
   output logic        mem_read,
   output logic [4:0]  alu_op,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic        fault,
   output logic [31:0] pc_init
);

   state_t state_reg, state_next;
   logic   t1_first_reg;
   logic   timeout;
   logic   fault_flag;
   ctrl_t  ctrl_dec, ctrl_out;

   logic [14:0] unused_ir;
   assign unused_ir = ir[14:0];

`ifdef BUS_SEQ_MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt_reg;
   logic             fault_reg;

   assign timeout = (state_reg == ST_T1) && !mem_ready &&
                    (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (clear) begin
         wait_cnt_reg <= '0;
         fault_reg    <= 1'b0;
      end else begin
         if (state_reg != ST_T1)
            wait_cnt_reg <= '0;
         else if (!mem_ready)
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
         if (timeout)
            fault_reg <= 1'b1;
      end
   end
   assign fault_flag = fault_reg;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(MEM_TIMEOUT);
   assign timeout        = 1'b0;
   assign fault_flag     = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (clear) begin
         state_reg    <= ST_IDLE;
         t1_first_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         t1_first_reg <= (state_reg != ST_T1);
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if ((start || run) && !fault_flag) state_next = ST_T0;
         ST_T0:   state_next = ST_T1;
         ST_T1: begin
            if (mem_ready)    state_next = ST_T2;
            else if (timeout) state_next = ST_IDLE;
         end
         ST_T2:   state_next = ST_T3;
         ST_T3:   state_next = (is_alu(ir[31:27]) || is_muldiv(ir[31:27])) ? ST_T4 : ST_END;
         ST_T4:   state_next = ST_T5;
         ST_T5:   state_next = is_muldiv(ir[31:27]) ? ST_T6 : ST_END;
         ST_T6:   state_next = ST_END;
         ST_END:  state_next = run ? ST_T0 : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   bus_ctrl_decode u_decode (
      .state    (state_reg),
      .t1_first (t1_first_reg),
      .opcode   (ir[31:27]),
      .ra       (ir[26:23]),
      .rb       (ir[22:19]),
      .rc       (ir[18:15]),
      .ctrl     (ctrl_dec)
   );

   // Strobes are forced off while clear is high so no partial writeback can escape
   assign ctrl_out  = clear ? '0 : ctrl_dec;
   assign bus_drive = ctrl_out.bus_drive;
   assign r_in      = ctrl_out.r_in;
   assign pc_in     = ctrl_out.pc_in;
   assign mar_in    = ctrl_out.mar_in;
   assign mdr_in    = ctrl_out.mdr_in;
   assign ir_in     = ctrl_out.ir_in;
   assign y_in      = ctrl_out.y_in;
   assign z_in      = ctrl_out.z_in;
   assign hi_in     = ctrl_out.hi_in;
   assign lo_in     = ctrl_out.lo_in;
   assign inc_pc    = ctrl_out.inc_pc;
   assign mem_read  = ctrl_out.mem_read;
   assign alu_op    = ctrl_out.alu_op;
   assign done      = ctrl_out.done;
   assign illegal   = ctrl_out.illegal;
   assign busy      = !clear && (state_reg != ST_IDLE);
   assign fault     = fault_flag;
   assign pc_init   = PC_RESET;

endmodule

// File: tb/tb_bus_ctrl_sequencer.sv
// Scoreboard bench for bus_ctrl_sequencer: per-cycle expected strobes are queued
// for each directed step and compared against the DUT one T-step at a time.
module tb_bus_ctrl_sequencer;

`ifdef BUS_SEQ_MEM_TIMEOUT_EN
   localparam int TB_TMO = 4;
`else
   localparam int TB_TMO = 16;
`endif
   localparam logic [31:0] TB_PC_RESET = 32'h0000_0100;

   // strobe order: pc mar mdr ir y z hi lo inc_pc mem_read
   localparam logic [9:0] S_PC = 10'h200, S_MAR = 10'h100, S_MDR = 10'h080, S_IR = 10'h040;
   localparam logic [9:0] S_Y = 10'h020, S_Z = 10'h010, S_HI = 10'h008, S_LO = 10'h004;
   localparam logic [9:0] S_INC = 10'h002, S_MRD = 10'h001;
   // flags order: busy done illegal fault
   localparam logic [3:0] F_B = 4'b1000, F_D = 4'b0100, F_IL = 4'b0010, F_F = 4'b0001;

   localparam logic [4:0] ADD = 5'd3, SUB = 5'd4, MUL = 5'd15, DIV = 5'd16;
   localparam logic [4:0] MFHI = 5'd24, MFLO = 5'd25, LD = 5'd2;

   logic        clock = 1'b0;
   logic        clear, run, start, mem_ready;
   logic [31:0] ir;
   logic [31:0] bus_drive, pc_init;
   logic [15:0] r_in;
   logic        pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read;
   logic [4:0]  alu_op;
   logic        busy, done, illegal, fault;

   typedef struct {
      string       tag;
      logic [31:0] bus;
      logic [15:0] rin;
      logic [9:0]  stb;
      logic [4:0]  aop;
      logic [3:0]  flg;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   always #5 clock = ~clock;

   bus_ctrl_sequencer #(.MEM_TIMEOUT(TB_TMO), .PC_RESET(TB_PC_RESET)) dut (
      .clock(clock), .clear(clear), .run(run), .start(start), .ir(ir),
      .mem_ready(mem_ready), .bus_drive(bus_drive), .r_in(r_in), .pc_in(pc_in),
      .mar_in(mar_in), .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
      .hi_in(hi_in), .lo_in(lo_in), .inc_pc(inc_pc), .mem_read(mem_read),
      .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal), .fault(fault),
      .pc_init(pc_init)
   );

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] c);
      return {op, a, b, c, 15'h0};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] bus, input logic [15:0] rin,
                       input logic [9:0] stb, input logic [4:0] aop, input logic [3:0] flg);
      exp_t e;
      e.tag = tag; e.bus = bus; e.rin = rin; e.stb = stb; e.aop = aop; e.flg = flg;
      sb.push_back(e);
   endtask

   task automatic push_fetch(input string name);
      push({name, ".T0"}, 32'h0010_0000, 16'h0, S_MAR | S_INC | S_Z, 5'd0, F_B);
      push({name, ".T1"}, 32'h0008_0000, 16'h0, S_PC | S_MDR | S_MRD, 5'd0, F_B);
      push({name, ".T2"}, 32'h0020_0000, 16'h0, S_IR, 5'd0, F_B);
   endtask

   task automatic check_one();
      exp_t        e;
      logic [9:0]  stb_obs;
      logic [3:0]  flg_obs;
      e       = sb.pop_front();
      stb_obs = {pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read};
      flg_obs = {busy, done, illegal, fault};
      $display("step %s: bus=%h r_in=%h stb=%b alu_op=%0d flags=%b", e.tag, bus_drive,
               r_in, stb_obs, alu_op, flg_obs);
      checks++;
      assert (bus_drive === e.bus) passed++;
      else $error("FAIL %s bus_drive got %h expected %h", e.tag, bus_drive, e.bus);
      checks++;
      assert (r_in === e.rin) passed++;
      else $error("FAIL %s r_in got %h expected %h", e.tag, r_in, e.rin);
      checks++;
      assert (stb_obs === e.stb) passed++;
      else $error("FAIL %s strobes got %b expected %b", e.tag, stb_obs, e.stb);
      checks++;
      assert (alu_op === e.aop) passed++;
      else $error("FAIL %s alu_op got %0d expected %0d", e.tag, alu_op, e.aop);
      checks++;
      assert (flg_obs === e.flg) passed++;
      else $error("FAIL %s busy/done/illegal/fault got %b expected %b", e.tag, flg_obs, e.flg);
      checks++;
      assert ($countones(bus_drive) <= 1) passed++;
      else $error("FAIL %s onehot bus_drive got %h expected at most one bit", e.tag, bus_drive);
   endtask

   task automatic drain();
      while (sb.size() > 0) begin
         check_one();
         if (sb.size() > 0) tick();
      end
   endtask

   task automatic fire();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      clear = 1'b1; run = 1'b0; start = 1'b0; mem_ready = 1'b1; ir = '0;
      tick(); tick();
      push("reset", 32'h0, 16'h0, 10'h0, 5'd0, 4'b0000);
      drain();
      clear = 1'b0;
      tick();
      push("idle", 32'h0, 16'h0, 10'h0, 5'd0, 4'b0000);
      drain();
      checks++;
      assert (pc_init === TB_PC_RESET) passed++;
      else $error("FAIL pc_init got %h expected %h", pc_init, TB_PC_RESET);

      // ADD R5,R2,R3
      ir = mk_ir(ADD, 4'd5, 4'd2, 4'd3);
      fire();
      push_fetch("add");
      push("add.T3", 32'h0000_0004, 16'h0, S_Y, 5'd0, F_B);
      push("add.T4", 32'h0000_0008, 16'h0, S_Z, ADD, F_B);
      push("add.T5", 32'h0008_0000, 16'h0020, 10'h0, 5'd0, F_B | F_D);
      push("add.END", 32'h0, 16'h0, 10'h0, 5'd0, F_B);
      push("add.IDLE", 32'h0, 16'h0, 10'h0, 5'd0, 4'b0000);
      drain();

      // MUL R2,R3 then MFHI R7 back-to-back using run
      run = 1'b1;
      ir  = mk_ir(MUL, 4'd0, 4'd2, 4'd3);
      fire();
      push_fetch("mul");
      push("mul.T3", 32'h0000_0004, 16'h0, S_Y, 5'd0, F_B);
      push("mul.T4", 32'h0000_0008, 16'h0, S_Z, MUL, F_B);
      push("mul.T5", 32'h0008_0000, 16'h0, S_LO, 5'd0, F_B);
      push("mul.T6", 32'h0004_0000, 16'h0, S_HI, 5'd0, F_B | F_D);
      drain();
      ir = mk_ir(MFHI, 4'd7, 4'd0, 4'd0);
      tick();
      push("mul.END", 32'h0, 16'h0, 10'h0, 5'd0, F_B);
      push_fetch("mfhi");
      push("mfhi.T3", 32'h0001_0000, 16'h0080, 10'h0, 5'd0, F_B | F_D);
      drain();
      run = 1'b0;
      tick();
      push("mfhi.END", 32'h0, 16'h0, 10'h0, 5'd0, F_B);
      push("mfhi.IDLE", 32'h0, 16'h0, 10'h0, 5'd0, 4'b0000);
      drain();

      // SUB R1,R4,R4 with a 5-cycle memory stall; start while busy must be ignored
      mem_ready = 1'b0;
      ir = mk_ir(SUB, 4'd1, 4'd4, 4'd4);
      fire();
      push("stall.T0", 32'h0010_0000, 16'h0, S_MAR | S_INC | S_Z, 5'd0, F_B);
      push("stall.T1c1", 32'h0008_0000, 16'h0, S_PC | S_MDR | S_MRD, 5'd0, F_B);
      drain();
      start = 1'b1;
      tick();
      for (int i = 2; i <= 6; i++)
         push($sformatf("stall.T1c%0d", i), 32'h0, 16'h0, S_MDR | S_MRD, 5'd0, F_B);
      drain();
      mem_ready = 1'b1;
      start = 1'b0;
      tick();
      push("stall.T2", 32'h0020_0000, 16'h0, S_IR, 5'd0, F_B);
      push("stall.T3", 32'h0000_0010, 16'h0, S_Y, 5'd0, F_B);
      push("stall.T4", 32'h0000_0010, 16'h0, S_Z, SUB, F_B);
      push("stall.T5", 32'h0008_0000, 16'h0002, 10'h0, 5'd0, F_B | F_D);
      push("stall.END", 32'h0, 16'h0, 10'h0, 5'd0, F_B);
      push("stall.IDLE", 32'h0, 16'h0, 10'h0, 5'd0, 4'b0000);
      drain();

      // unsupported opcode
      ir = mk_ir(LD, 4'd1, 4'd1, 4'd1);
      fire();
      push_fetch("ill");
      push("ill.T3", 32'h0, 16'h0, 10'h0, 5'd0, F_B | F_IL);
      push("ill.END", 32'h0, 16'h0, 10'h0, 5'd0, F_B);
      push("ill.IDLE", 32'h0, 16'h0, 10'h0, 5'd0, 4'b0000);
      drain();

      // MFLO R15 (top register boundary)
      ir = mk_ir(MFLO, 4'd15, 4'd0, 4'd0);
      fire();
      push_fetch("mflo");
      push("mflo.T3", 32'h0002_0000, 16'h8000, 10'h0, 5'd0, F_B | F_D);
      push("mflo.END", 32'h0, 16'h0, 10'h0, 5'd0, F_B);
      push("mflo.IDLE", 32'h0, 16'h0, 10'h0, 5'd0, 4'b0000);
      drain();

      // DIV R0,R6,R7 aborted by clear in T4: no HI/LO writeback may follow
      ir = mk_ir(DIV, 4'd0, 4'd6, 4'd7);
      fire();
      push_fetch("div");
      push("div.T3", 32'h0000_0040, 16'h0, S_Y, 5'd0, F_B);
      push("div.T4", 32'h0000_0080, 16'h0, S_Z, DIV, F_B);
      drain();
      clear = 1'b1;
      #1;
      push("div.clrT4", 32'h0, 16'h0, 10'h0, 5'd0, 4'b0000);
      drain();
      tick();
      push("div.clrIDLE", 32'h0, 16'h0, 10'h0, 5'd0, 4'b0000);
      drain();
      clear = 1'b0;
      tick();
      push("div.after1", 32'h0, 16'h0, 10'h0, 5'd0, 4'b0000);
      push("div.after2", 32'h0, 16'h0, 10'h0, 5'd0, 4'b0000);
      drain();

`ifdef BUS_SEQ_MEM_TIMEOUT_EN
      // memory never answers: fault after TB_TMO stall cycles, start ignored until clear
      mem_ready = 1'b0;
      ir = mk_ir(ADD, 4'd1, 4'd2, 4'd3);
      fire();
      push("tmo.T0", 32'h0010_0000, 16'h0, S_MAR | S_INC | S_Z, 5'd0, F_B);
      push("tmo.T1c1", 32'h0008_0000, 16'h0, S_PC | S_MDR | S_MRD, 5'd0, F_B);
      for (int i = 2; i <= TB_TMO; i++)
         push($sformatf("tmo.T1c%0d", i), 32'h0, 16'h0, S_MDR | S_MRD, 5'd0, F_B);
      push("tmo.IDLE", 32'h0, 16'h0, 10'h0, 5'd0, F_F);
      drain();
      fire();
      push("tmo.start_ignored", 32'h0, 16'h0, 10'h0, 5'd0, F_F);
      drain();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      push("tmo.cleared", 32'h0, 16'h0, 10'h0, 5'd0, 4'b0000);
      drain();
      mem_ready = 1'b1;
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
